// File: rtl/logic_op_pkg.sv
// Shared opcode encoding, packet FSM states and result-entry field layout
// for logic_op_unit.
package logic_op_pkg;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_XOR     = 3'd2;
    localparam logic [2:0] OP_NAND    = 3'd3;
    localparam logic [2:0] OP_NOR     = 3'd4;
    localparam logic [2:0] OP_XNOR    = 3'd5;
    localparam logic [2:0] OP_ACC_AND = 3'd6;
    localparam logic [2:0] OP_ACC_OR  = 3'd7;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_BODY  = 1'b1
    } pkt_state_e;

    // Entry layout: {err, zero, last, result[W-1:0]}; offsets are relative to bit W.
    localparam int unsigned PL_EXTRA    = 3;
    localparam int unsigned PL_LAST_OFS = 0;
    localparam int unsigned PL_ZERO_OFS = 1;
    localparam int unsigned PL_ERR_OFS  = 2;

    function automatic int unsigned pl_width(input int unsigned w);
        return w + PL_EXTRA;
    endfunction

endpackage

// File: rtl/op_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. Main entry drives the outputs; the
// skid entry catches one beat on a stall. o_ready is registered.
module op_skid_buf #(
    parameter int unsigned Width = 11
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [Width-1:0] o_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_ready;
    logic [Width-1:0] r_main_data;
    logic [Width-1:0] r_skid_data;

    logic             w_main_valid_d;
    logic             w_skid_valid_d;
    logic [Width-1:0] w_main_data_d;
    logic [Width-1:0] w_skid_data_d;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_valid & r_ready;
    assign w_pop  = r_main_valid & i_ready;

    always_comb begin
        w_main_valid_d = r_main_valid;
        w_main_data_d  = r_main_data;
        w_skid_valid_d = r_skid_valid;
        w_skid_data_d  = r_skid_data;
        if (r_skid_valid) begin
            // r_ready is low here, so no push can coincide with the drain.
            if (w_pop) begin
                w_main_data_d  = r_skid_data;
                w_skid_valid_d = 1'b0;
            end
        end else if (w_push) begin
            if (!r_main_valid || w_pop) begin
                w_main_valid_d = 1'b1;
                w_main_data_d  = i_data;
            end else begin
                w_skid_valid_d = 1'b1;
                w_skid_data_d  = i_data;
            end
        end else if (w_pop) begin
            w_main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_main_valid <= w_main_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_ready      <= !w_skid_valid_d;
            r_main_data  <= w_main_data_d;
            r_skid_data  <= w_skid_data_d;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule

// File: rtl/logic_op_unit.sv
// Registered bitwise logic stage with per-packet ACC_AND/ACC_OR accumulation.
// Define LOGIC_OP_XOR_EN to implement XOR/XNOR; otherwise they flag OUT_ERR.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [2:0]   i_op,
    input  logic         i_in_last,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out,
    output logic         o_out_last,
    output logic         o_out_zero,
    output logic         o_out_err
);

    localparam int unsigned PW = pl_width(W);

    pkt_state_e   r_state;
    pkt_state_e   w_state_d;
    logic [W-1:0] r_acc;
    logic [W-1:0] w_acc_d;
    logic [W-1:0] w_result;
    logic         w_err;
    logic         w_first;
    logic         w_is_acc;
    logic         w_accept;
    logic         w_in_ready;
    logic [PW-1:0] w_payload;
    logic [PW-1:0] w_out_payload;

    assign w_accept = i_in_valid & w_in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_FIRST;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_accept) begin
            w_state_d = i_in_last ? ST_FIRST : ST_BODY;
        end
    end

    always_comb begin
        w_first  = (r_state == ST_FIRST);
        w_is_acc = 1'b0;
        w_err    = 1'b0;
        w_result = '0;
        case (i_op)
            OP_AND:  w_result = i_a & i_b;
            OP_OR:   w_result = i_a | i_b;
            OP_NAND: w_result = ~(i_a & i_b);
            OP_NOR:  w_result = ~(i_a | i_b);
`ifdef LOGIC_OP_XOR_EN
            OP_XOR:  w_result = i_a ^ i_b;
            OP_XNOR: w_result = ~(i_a ^ i_b);
`else
            OP_XOR,
            OP_XNOR: w_err = 1'b1;
`endif
            OP_ACC_AND: begin
                w_is_acc = 1'b1;
                w_result = w_first ? i_a : (r_acc & i_a);
            end
            OP_ACC_OR: begin
                w_is_acc = 1'b1;
                w_result = w_first ? i_a : (r_acc | i_a);
            end
            default: w_result = '0;
        endcase
    end

    always_comb begin
        w_acc_d = r_acc;
        if (w_accept && w_is_acc) begin
            w_acc_d = w_result;
        end
    end

    assign w_payload = {w_err, (w_result == '0), i_in_last, w_result};

    op_skid_buf #(
        .Width (PW)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_in_valid),
        .o_ready (w_in_ready),
        .i_data  (w_payload),
        .o_valid (o_out_valid),
        .i_ready (i_out_ready),
        .o_data  (w_out_payload)
    );

    assign o_in_ready = w_in_ready;
    assign o_out      = w_out_payload[W-1:0];
    assign o_out_last = w_out_payload[W+PL_LAST_OFS];
    assign o_out_zero = w_out_payload[W+PL_ZERO_OFS];
    assign o_out_err  = w_out_payload[W+PL_ERR_OFS];

endmodule
